// File: rtl/hpram_cmd_arbiter.sv
// hpram_cmd_arbiter
//   Shares the single HyperRAM memory-interface command port between a write
//   requester and a read requester (same dma clock). One burst at a time,
//   round-robin between the two, fixed idle gap after every burst, and no
//   traffic at all until the memory reports init_calib.
//
// Optional feature macro: HPARB_TIMEOUT_EN
//   defined     : read bursts that do not complete within RD_TIMEOUT cycles of
//                 cmd_en set sticky O_r_err and release the port.
//   not defined : RD_WAIT waits indefinitely, O_r_err tied low.
//
// Ports
//   I_clk, I_rst_n            clock, asynchronous active-low reset
//   I_init_calib              memory ready
//   I_w_req/I_w_addr/O_w_ack  write request handshake (req held until ack)
//   O_w_dreq/I_w_data         write beat strobe and FWFT write data
//   I_r_req/I_r_addr/O_r_ack  read request handshake (req held until ack)
//   O_r_valid/O_r_data        registered read beats
//   O_r_err                   sticky read timeout flag
//   O_cmd/O_cmd_en/O_addr     memory command port (0=write, 1=read)
//   O_wr_data/O_data_mask     memory write data, mask always 0
//   I_rd_valid/I_rd_data      memory read return
module hpram_cmd_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned CMD_GAP    = 4,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_init_calib,
  input  logic                  I_w_req,
  input  logic [ADDR_W-1:0]     I_w_addr,
  output logic                  O_w_ack,
  output logic                  O_w_dreq,
  input  logic [DATA_W-1:0]     I_w_data,
  input  logic                  I_r_req,
  input  logic [ADDR_W-1:0]     I_r_addr,
  output logic                  O_r_ack,
  output logic                  O_r_valid,
  output logic [DATA_W-1:0]     O_r_data,
  output logic                  O_r_err,
  output logic                  O_cmd,
  output logic                  O_cmd_en,
  output logic [ADDR_W-1:0]     O_addr,
  output logic [DATA_W-1:0]     O_wr_data,
  output logic [DATA_W/8-1:0]   O_data_mask,
  input  logic                  I_rd_valid,
  input  logic [DATA_W-1:0]     I_rd_data
);

  localparam int unsigned BCNT_W = $clog2(BEATS + 1);
  localparam int unsigned GCNT_W = $clog2(CMD_GAP + 1);

  if (BEATS < 1 || CMD_GAP < 1 || RD_TIMEOUT < 1) begin : g_bad_param
    $error("hpram_cmd_arbiter: BEATS, CMD_GAP and RD_TIMEOUT must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, GAP} state_t;

  state_t              state;
  logic [BCNT_W-1:0]   beat_cnt;
  logic [GCNT_W-1:0]   gap_cnt;
  logic                last_rd;     // last grant went to the read side
  logic                grant_w_c;
  logic                grant_r_c;
  logic                rd_last_c;
  logic                tmo_c;

  // Round-robin pick: on a tie the side that did not win last time goes
  always_comb begin
    grant_w_c = 1'b0;
    grant_r_c = 1'b0;
    if (state == IDLE && I_init_calib) begin
      grant_w_c = I_w_req && (!I_r_req || last_rd);
      grant_r_c = I_r_req && !grant_w_c;
    end
  end

  assign rd_last_c   = (state == RD_WAIT) && I_rd_valid &&
                       (beat_cnt == BCNT_W'(BEATS - 1));
  assign O_wr_data   = O_w_dreq ? I_w_data : '0;
  assign O_data_mask = '0;

`ifdef HPARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

  logic [TMR_W-1:0] rd_tmr;

  // Timer is 0 on the cmd_en cycle (first RD_WAIT cycle); a completing beat wins
  assign tmo_c = (state == RD_WAIT) && !rd_last_c &&
                 (rd_tmr == TMR_W'(RD_TIMEOUT - 1));

  // Read watchdog and sticky error flag
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_tmr  <= '0;
      O_r_err <= 1'b0;
    end else begin
      rd_tmr <= (state == RD_WAIT) ? rd_tmr + TMR_W'(1) : '0;
      if (tmo_c) begin
        O_r_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_c   = 1'b0;
  assign O_r_err = 1'b0;
`endif

  // Arbiter FSM with registered command/handshake outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      last_rd   <= 1'b1;
      O_cmd_en  <= 1'b0;
      O_cmd     <= 1'b0;
      O_addr    <= '0;
      O_w_ack   <= 1'b0;
      O_r_ack   <= 1'b0;
      O_w_dreq  <= 1'b0;
      O_r_valid <= 1'b0;
      O_r_data  <= '0;
    end else begin
      O_cmd_en  <= 1'b0;
      O_w_ack   <= 1'b0;
      O_r_ack   <= 1'b0;
      // Read beats are forwarded only while a read burst is outstanding
      O_r_valid <= (state == RD_WAIT) && I_rd_valid;
      if (state == RD_WAIT && I_rd_valid) begin
        O_r_data <= I_rd_data;
      end

      unique case (state)
        IDLE: begin
          if (grant_w_c) begin
            O_cmd_en <= 1'b1;
            O_cmd    <= 1'b0;
            O_addr   <= I_w_addr;
            O_w_ack  <= 1'b1;
            O_w_dreq <= 1'b1;
            beat_cnt <= '0;
            last_rd  <= 1'b0;
            state    <= WR_BURST;
          end else if (grant_r_c) begin
            O_cmd_en <= 1'b1;
            O_cmd    <= 1'b1;
            O_addr   <= I_r_addr;
            O_r_ack  <= 1'b1;
            beat_cnt <= '0;
            last_rd  <= 1'b1;
            state    <= RD_WAIT;
          end
        end

        WR_BURST: begin
          if (beat_cnt == BCNT_W'(BEATS - 1)) begin
            O_w_dreq <= 1'b0;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
          end
        end

        RD_WAIT: begin
          if (I_rd_valid) begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
          end
          if (rd_last_c || tmo_c) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GCNT_W'(CMD_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
